fifo_stream: RTL and testbench

- Second-generation synchronous stream FIFO: single clock, valid/ready on both sides, first-word-fall-through read port with a registered output stage.
- Adds to the first generation: exposed fill level, runtime-programmable almost-full/almost-empty flags, synchronous flush, and an optional sticky overflow flag.
- Sits between producer and consumer datapaths wherever rate decoupling and back-pressure headroom are needed.

---
 rtl/fifo_stream.sv | 192 +++++++++++++++++++
 tb/tb_fifo_stream.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_stream.sv
// Single-clock first-word-fall-through stream FIFO with level, almost-full/empty flags and flush.
// Optional sticky overflow flag is built when FIFO_STREAM_OVERFLOW_EN is defined.
module fifo_stream #(
    parameter int DATA_WIDTH  = 32,
    parameter int FIFO_DEPTH  = 512,
    parameter int FIFO_SKID   = 0,
    parameter int COUNT_WIDTH = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                   clkIn,
    input  logic                   rstnIn,
    input  logic                   flushIn,
    input  logic [DATA_WIDTH-1:0]  wrDataIn,
    input  logic                   wrValidIn,
    output logic                   wrReadyOut,
    output logic [DATA_WIDTH-1:0]  rdDataOut,
    output logic                   rdValidOut,
    input  logic                   rdReadyIn,
    input  logic [COUNT_WIDTH-1:0] almostFullThreshIn,
    input  logic [COUNT_WIDTH-1:0] almostEmptyThreshIn,
    output logic [COUNT_WIDTH-1:0] countOut,
    output logic                   almostFullOut,
    output logic                   almostEmptyOut,
    output logic                   overflowOut
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [COUNT_WIDTH-1:0] DEPTH_C     = COUNT_WIDTH'(FIFO_DEPTH);
    localparam logic [COUNT_WIDTH-1:0] READY_LIMIT = COUNT_WIDTH'(FIFO_DEPTH - FIFO_SKID);

    // Handshake: a word moves on a rising edge when valid and ready are both high on that side.
    // Write side: wrReadyOut is advisory when FIFO_SKID>0; a write is taken whenever a slot is free
    // (or the head is popped in the same cycle). Read side: rdDataOut is stable while
    // rdValidOut=1 and rdReadyIn=0.

    logic [COUNT_WIDTH-1:0] countQ;
    logic [COUNT_WIDTH-1:0] nextCount;
    logic [COUNT_WIDTH-1:0] flagCount;
    logic                   rdValidQ;
    logic                   wrReadyQ;
    logic                   almostFullQ;
    logic                   almostEmptyQ;
    logic                   rdEn;
    logic                   wrEn;

    logic [DATA_WIDTH-1:0]  mem [FIFO_DEPTH];
    logic [AW-1:0]          wrPtr;
    logic [AW-1:0]          rdPtr;
    logic [COUNT_WIDTH-1:0] ramCount;
    logic                   ramEmpty;
    logic                   ramWr;
    logic                   ramRd;
    logic                   rdPend;
    logic [DATA_WIDTH-1:0]  ramQ;
    logic                   bypass;

    logic [1:0]             pipeCnt;
    logic [1:0]             pipeCntNext;
    logic [DATA_WIDTH-1:0]  pipeData0;
    logic [DATA_WIDTH-1:0]  pipeData1;
    logic [DATA_WIDTH-1:0]  pipeData0Next;
    logic [DATA_WIDTH-1:0]  pipeData1Next;
    logic [2:0]             pipeOcc;
    logic [2:0]             pipeRoom;

    assign rdEn      = rdValidQ & rdReadyIn;
    assign wrEn      = wrValidIn & ((countQ < DEPTH_C) | rdEn) & ~flushIn;
    assign nextCount = countQ + COUNT_WIDTH'(wrEn) - COUNT_WIDTH'(rdEn);
    assign flagCount = flushIn ? '0 : nextCount;

    // Pipeline occupancy counts the RAM read in flight; it may hold at most one word after
    // this cycle's pop so the in-flight word always has a slot when it lands.
    assign pipeOcc  = {1'b0, pipeCnt} + {2'b00, rdPend};
    assign pipeRoom = 3'd1 + {2'b00, rdEn};
    assign ramEmpty = (ramCount == '0);
    assign bypass   = wrEn & ramEmpty & (pipeOcc <= pipeRoom);
    assign ramWr    = wrEn & ~bypass;
    assign ramRd    = ~ramEmpty & (pipeOcc <= pipeRoom);

    // Output pipeline: pop shifts, then the older RAM word is appended before a bypassed write.
    always_comb begin
        pipeData0Next = pipeData0;
        pipeData1Next = pipeData1;
        pipeCntNext   = pipeCnt;
        if (rdEn) begin
            pipeData0Next = pipeData1;
            pipeCntNext   = pipeCnt - 2'd1;
        end
        if (rdPend) begin
            if (pipeCntNext == 2'd0) begin
                pipeData0Next = ramQ;
            end else begin
                pipeData1Next = ramQ;
            end
            pipeCntNext = pipeCntNext + 2'd1;
        end
        if (bypass) begin
            if (pipeCntNext == 2'd0) begin
                pipeData0Next = wrDataIn;
            end else begin
                pipeData1Next = wrDataIn;
            end
            pipeCntNext = pipeCntNext + 2'd1;
        end
    end

    always_ff @(posedge clkIn) begin
        if (!rstnIn) begin
            countQ       <= '0;
            rdValidQ     <= 1'b0;
            wrReadyQ     <= 1'b0;
            almostFullQ  <= 1'b0;
            almostEmptyQ <= 1'b1;
            pipeCnt      <= 2'd0;
            rdPend       <= 1'b0;
            ramCount     <= '0;
            wrPtr        <= '0;
            rdPtr        <= '0;
        end else begin
            countQ       <= flagCount;
            rdValidQ     <= (flagCount != '0);
            wrReadyQ     <= (flagCount < READY_LIMIT);
            almostFullQ  <= (flagCount >= almostFullThreshIn);
            almostEmptyQ <= (flagCount <= almostEmptyThreshIn);
            if (flushIn) begin
                pipeCnt  <= 2'd0;
                rdPend   <= 1'b0;
                ramCount <= '0;
                wrPtr    <= '0;
                rdPtr    <= '0;
            end else begin
                pipeCnt  <= pipeCntNext;
                rdPend   <= ramRd;
                ramCount <= ramCount + COUNT_WIDTH'(ramWr) - COUNT_WIDTH'(ramRd);
                if (ramWr) begin
                    wrPtr <= wrPtr + AW'(1);
                end
                if (ramRd) begin
                    rdPtr <= rdPtr + AW'(1);
                end
            end
        end
    end

    always_ff @(posedge clkIn) begin
        pipeData0 <= pipeData0Next;
        pipeData1 <= pipeData1Next;
    end

    always_ff @(posedge clkIn) begin
        if (ramWr) begin
            mem[wrPtr] <= wrDataIn;
        end
        if (ramRd) begin
            ramQ <= mem[rdPtr];
        end
    end

    assign countOut       = countQ;
    assign rdValidOut     = rdValidQ;
    assign wrReadyOut     = wrReadyQ;
    assign almostFullOut  = almostFullQ;
    assign almostEmptyOut = almostEmptyQ;
    assign rdDataOut      = pipeData0;

`ifdef FIFO_STREAM_OVERFLOW_EN
    logic overflowQ;
    logic overflowEvent;

    assign overflowEvent = wrValidIn & (countQ == DEPTH_C) & ~rdEn & ~flushIn;

    always_ff @(posedge clkIn) begin
        if (!rstnIn || flushIn) begin
            overflowQ <= 1'b0;
        end else if (overflowEvent) begin
            overflowQ <= 1'b1;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clkIn) begin
        if (rstnIn && overflowEvent) begin
            $error("fifo_stream: write attempted while full and not popping");
        end
    end
`endif

    assign overflowOut = overflowQ;
`else
    assign overflowOut = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_stream.sv
// Bench for fifo_stream (DATA_WIDTH=16, FIFO_DEPTH=8, FIFO_SKID=2): directed vectors, a random
// phase, a per-cycle reference model of level/flags and a scoreboard queue for read data.
module tb_fifo_stream;

    localparam int DW    = 16;
    localparam int DEPTH = 8;
    localparam int SKID  = 2;
    localparam int CW    = 4;
`ifdef FIFO_STREAM_OVERFLOW_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic          clkIn = 1'b0;
    logic          rstnIn = 1'b0;
    logic          flushIn = 1'b0;
    logic [DW-1:0] wrDataIn = '0;
    logic          wrValidIn = 1'b0;
    logic          wrReadyOut;
    logic [DW-1:0] rdDataOut;
    logic          rdValidOut;
    logic          rdReadyIn = 1'b0;
    logic [CW-1:0] almostFullThreshIn = CW'(6);
    logic [CW-1:0] almostEmptyThreshIn = CW'(1);
    logic [CW-1:0] countOut;
    logic          almostFullOut;
    logic          almostEmptyOut;
    logic          overflowOut;

    fifo_stream #(
        .DATA_WIDTH(DW),
        .FIFO_DEPTH(DEPTH),
        .FIFO_SKID(SKID)
    ) dut (
        .clkIn(clkIn),
        .rstnIn(rstnIn),
        .flushIn(flushIn),
        .wrDataIn(wrDataIn),
        .wrValidIn(wrValidIn),
        .wrReadyOut(wrReadyOut),
        .rdDataOut(rdDataOut),
        .rdValidOut(rdValidOut),
        .rdReadyIn(rdReadyIn),
        .almostFullThreshIn(almostFullThreshIn),
        .almostEmptyThreshIn(almostEmptyThreshIn),
        .countOut(countOut),
        .almostFullOut(almostFullOut),
        .almostEmptyOut(almostEmptyOut),
        .overflowOut(overflowOut)
    );

    // clock / reset
    always #5 clkIn = ~clkIn;

    int            total = 0;
    int            bad = 0;
    bit            monOn = 1'b0;
    logic [DW-1:0] exp_q[$];
    int            mCount = 0;
    logic          mReady = 1'b0;
    logic          mAF = 1'b0;
    logic          mAE = 1'b1;
    logic          mOvf = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 40) begin
                $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
            end
        end
    endtask

    // reference model: level, flags and expected data, advanced on each rising edge
    always @(posedge clkIn) begin
        logic rdE;
        logic wrE;
        if (!rstnIn) begin
            mCount = 0;
            mReady = 1'b0;
            mAF    = 1'b0;
            mAE    = 1'b1;
            mOvf   = 1'b0;
            exp_q.delete();
        end else begin
            rdE = (mCount != 0) && rdReadyIn;
            wrE = wrValidIn && ((mCount < DEPTH) || rdE) && !flushIn;
            if (flushIn) begin
                mCount = 0;
                mOvf   = 1'b0;
                exp_q.delete();
            end else begin
                if (OVF_EN && wrValidIn && (mCount == DEPTH) && !rdE) mOvf = 1'b1;
                if (wrE) exp_q.push_back(wrDataIn);
                mCount = mCount + int'(wrE) - int'(rdE);
            end
            mReady = (mCount < DEPTH - SKID);
            mAF    = (mCount >= int'(almostFullThreshIn));
            mAE    = (mCount <= int'(almostEmptyThreshIn));
        end
    end

    // monitor: compares outputs against the model and pops the scoreboard on each read handshake
    always @(negedge clkIn) begin
        logic [DW-1:0] e;
        if (monOn) begin
            check("countOut", countOut, mCount);
            check("rdValidOut", rdValidOut, (mCount != 0));
            check("wrReadyOut", wrReadyOut, mReady);
            check("almostFullOut", almostFullOut, mAF);
            check("almostEmptyOut", almostEmptyOut, mAE);
            check("overflowOut", overflowOut, mOvf);
            if (rdValidOut && rdReadyIn) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL rdData: got %0h expected none (queue empty) at %0t", rdDataOut, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("rdData", rdDataOut, e);
                end
            end
        end
    end

    // driver tasks
    task automatic step();
        @(posedge clkIn);
        #1;
    endtask

    task automatic drive(input logic wv, input logic [DW-1:0] d, input logic rr);
        wrValidIn = wv;
        wrDataIn  = d;
        rdReadyIn = rr;
    endtask

    initial begin
        logic [DW-1:0] d;
        rstnIn = 1'b0;
        step();
        monOn = 1'b1;
        step();

        // release reset and write on the very first cycle
        rstnIn = 1'b1;
        drive(1'b1, 16'h0001, 1'b0);
        step();
        check("t1_wrReady", wrReadyOut, 1);
        check("t1_rdValid", rdValidOut, 1);
        check("t1_count", countOut, 1);
        check("t1_rdData", rdDataOut, 16'h0001);
        drive(1'b0, '0, 1'b1);
        step();
        drive(1'b0, '0, 1'b0);
        step();

        // fill to full with skid, then one refused write
        for (int i = 0; i < 8; i++) begin
            d = 16'h00A0 + 16'(i);
            drive(1'b1, d, 1'b0);
            step();
            if (i == 4) check("t2_ready_at5", wrReadyOut, 1);
            if (i == 5) begin
                check("t2_ready_at6", wrReadyOut, 0);
                check("t2_af_at6", almostFullOut, 1);
            end
        end
        check("t2_count_full", countOut, 8);
        drive(1'b1, 16'h00A8, 1'b0);
        step();
        check("t2_count_refused", countOut, 8);
        check("t2_overflow", overflowOut, OVF_EN);

        // full-rate write and read while full
        for (int i = 0; i < 20; i++) begin
            d = 16'h00C0 + 16'(i);
            drive(1'b1, d, 1'b1);
            step();
            check("t3_count", countOut, 8);
            check("t3_rdValid", rdValidOut, 1);
        end
        drive(1'b0, '0, 1'b1);
        repeat (8) step();
        check("t3_drained", countOut, 0);

        // count=1: write and pop together
        drive(1'b1, 16'h00B0, 1'b0);
        step();
        drive(1'b1, 16'h00B1, 1'b1);
        step();
        check("t4_rdData", rdDataOut, 16'h00B1);
        check("t4_rdValid", rdValidOut, 1);
        check("t4_count", countOut, 1);
        drive(1'b0, '0, 1'b1);
        step();

        // flush at count=5 with a concurrent write
        for (int i = 0; i < 5; i++) begin
            d = 16'h00D0 + 16'(i);
            drive(1'b1, d, 1'b0);
            step();
        end
        check("t5_count5", countOut, 5);
        flushIn = 1'b1;
        drive(1'b1, 16'h00DD, 1'b0);
        step();
        flushIn = 1'b0;
        drive(1'b0, '0, 1'b0);
        check("t5_count", countOut, 0);
        check("t5_rdValid", rdValidOut, 0);
        check("t5_ae", almostEmptyOut, 1);
        check("t5_overflow", overflowOut, 0);
        check("t5_wrReady", wrReadyOut, 1);
        drive(1'b1, 16'h00E0, 1'b0);
        step();
        drive(1'b0, '0, 1'b1);
        step();
        drive(1'b0, '0, 1'b0);

        // threshold boundaries: AE=0 means empty, AF=8 means full, AF=0 after flush
        almostEmptyThreshIn = CW'(0);
        almostFullThreshIn  = CW'(8);
        step();
        for (int i = 0; i < 8; i++) begin
            d = 16'h00F0 + 16'(i);
            drive(1'b1, d, 1'b0);
            step();
            if (i == 0) check("t6_ae_at1", almostEmptyOut, 0);
            if (i == 6) check("t6_af_at7", almostFullOut, 0);
        end
        check("t6_af_at8", almostFullOut, 1);
        drive(1'b0, '0, 1'b0);
        flushIn = 1'b1;
        almostFullThreshIn = CW'(0);
        step();
        flushIn = 1'b0;
        check("t6_af_thresh0", almostFullOut, 1);
        check("t6_ae_empty", almostEmptyOut, 1);
        almostFullThreshIn  = CW'(6);
        almostEmptyThreshIn = CW'(1);
        step();

        // random traffic with occasional flush, threshold changes and one mid-run reset
        for (int i = 0; i < 10000; i++) begin
            drive(1'($urandom_range(0, 1)), DW'($urandom_range(0, 16'hFFFF)), 1'($urandom_range(0, 1)));
            flushIn = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 99) == 0) begin
                almostFullThreshIn  = CW'($urandom_range(0, DEPTH));
                almostEmptyThreshIn = CW'($urandom_range(0, DEPTH));
            end
            rstnIn = (i != 5000);
            step();
        end
        rstnIn  = 1'b1;
        flushIn = 1'b0;
        drive(1'b0, '0, 1'b1);
        repeat (12) step();
        check("final_count", countOut, 0);
        check("final_queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
